fpga_tile: RTL and testbench

// - One island-style FPGA tile: 4-input CLB, right connection block (CB_R) on 3 vertical tracks,

---
 rtl/fpga_tile.sv | 167 ++++++++++++++++
 tb/tb_fpga_tile.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_tile.sv
// -----------------------------------------------------------------------------
// fpga_tile: one island-style FPGA tile.
//   - 4-input CLB (LUT16, optional output FF, two passthrough muxes)
//   - CB_R: right connection block on the 3 vertical tracks (sc_V_i)
//   - CB_B: bottom connection block on the 3 horizontal tracks (sc_H_i)
//   - SB  : switch block driving the outgoing tracks (tri-state)
// Everything is steered by a 77-bit configuration word loaded in parallel.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   wr_en, bits     parallel configuration load strobe and word
//   cl_V_i, cl_H_i  CLB up_i / left_i from the neighbouring connection blocks
//   lc_V_i, lc_H_i  neighbour CLB outputs, injectable by CB_B / CB_R
//   sc_V_i, sc_H_i  vertical tracks from above / horizontal tracks from the left
//   lc_V_o, lc_H_o  CLB result to the tile above / to the left
//   cl_V_o, cl_H_o  CB_B / CB_R picks to the tile below / to the right
//   sc_V_o, sc_H_o  tracks leaving downward / rightward (tri-state)
//
// Config map
//   [76:73] reserved      [72] down_o=up_i   [71] right_o=left_i   [70] registered
//   [69:54] LUT16 truth table, addr = {up, down, right, left}
//   [53:48] reserved      [47:42] CB_R inject {lc_H_i, right_o} per track
//   [41:39] cl_H_o select [38:36] right_i select
//   [35:30] reserved      [29:24] CB_B inject {lc_V_i, down_o} per track
//   [23:21] cl_V_o select [20:18] down_i select
//   [17:0]  SB, 6 bits per track: [2:0] drives sc_V_o[t], [5:3] drives sc_H_o[t]
// -----------------------------------------------------------------------------
module fpga_tile #(
    parameter int unsigned W     = 3,
    parameter int unsigned CFG_W = 77
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [CFG_W-1:0] bits,
    input  logic             cl_V_i,
    input  logic             cl_H_i,
    input  logic             lc_V_i,
    input  logic             lc_H_i,
    input  logic [W-1:0]     sc_V_i,
    input  logic [W-1:0]     sc_H_i,
    output logic             lc_V_o,
    output logic             lc_H_o,
    output logic             cl_V_o,
    output logic             cl_H_o,
    output logic [W-1:0]     sc_V_o,
    output logic [W-1:0]     sc_H_o
);

    localparam logic [2:0] SbZ        = 3'b000;
    localparam logic [2:0] SbStraight = 3'b001;
    localparam logic [2:0] SbTurn     = 3'b010;
    localparam logic [2:0] SbInjR     = 3'b011;
    localparam logic [2:0] SbInjB     = 3'b100;

    logic [CFG_W-1:0] r_cfg;
    logic             r_lut;

    logic [15:0] w_lut_tt;
    logic [3:0]  w_addr;
    logic        w_lut;
    logic        w_result;
    logic        w_right_in;
    logic        w_down_in;
    logic        w_right_out;
    logic        w_down_out;
    logic [W-1:0] w_inj_r_en;
    logic [W-1:0] w_inj_r_val;
    logic [W-1:0] w_inj_b_en;
    logic [W-1:0] w_inj_b_val;
    logic [W-1:0] w_v_en;
    logic [W-1:0] w_v_val;
    logic [W-1:0] w_h_en;
    logic [W-1:0] w_h_val;
    logic         w_unused_cfg;

    // Anything other than exactly one bit set yields 0, so picks never float.
    function automatic logic f_pick(input logic [2:0] sel, input logic [2:0] src);
        logic res;
        case (sel)
            3'b001:  res = src[0];
            3'b010:  res = src[1];
            3'b100:  res = src[2];
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg <= '0;
        end else if (wr_en) begin
            r_cfg <= bits;
        end
    end

    // The CLB FF samples the raw LUT every edge, whether or not it is selected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lut <= 1'b0;
        end else begin
            r_lut <= w_lut;
        end
    end

    // Connection-block picks
    assign w_right_in = f_pick(r_cfg[38:36], sc_V_i);
    assign cl_H_o     = f_pick(r_cfg[41:39], sc_V_i);
    assign w_down_in  = f_pick(r_cfg[20:18], sc_H_i);
    assign cl_V_o     = f_pick(r_cfg[23:21], sc_H_i);

    // CLB
    assign w_lut_tt    = r_cfg[69:54];
    assign w_addr      = {cl_V_i, w_down_in, w_right_in, cl_H_i};
    assign w_lut       = w_lut_tt[w_addr];
    assign w_result    = r_cfg[70] ? r_lut : w_lut;
    assign w_right_out = r_cfg[71] ? cl_H_i : w_result;
    assign w_down_out  = r_cfg[72] ? cl_V_i : w_result;
    assign lc_V_o      = w_result;
    assign lc_H_o      = w_result;

    // Inject sources and switch-block decode
    always_comb begin
        w_inj_r_en  = '0;
        w_inj_r_val = '0;
        w_inj_b_en  = '0;
        w_inj_b_val = '0;
        w_v_en      = '0;
        w_v_val     = '0;
        w_h_en      = '0;
        w_h_val     = '0;
        for (int t = 0; t < 3; t++) begin
            // Bit 0 of each inject pair (local CLB output) has priority.
            w_inj_r_en[t]  = |r_cfg[42+2*t +: 2];
            w_inj_r_val[t] = r_cfg[42+2*t] ? w_right_out : lc_H_i;
            w_inj_b_en[t]  = |r_cfg[24+2*t +: 2];
            w_inj_b_val[t] = r_cfg[24+2*t] ? w_down_out : lc_V_i;

            case (r_cfg[6*t +: 3])
                SbStraight: begin w_v_en[t] = 1'b1;          w_v_val[t] = sc_V_i[t];      end
                SbTurn:     begin w_v_en[t] = 1'b1;          w_v_val[t] = sc_H_i[t];      end
                SbInjR:     begin w_v_en[t] = w_inj_r_en[t]; w_v_val[t] = w_inj_r_val[t]; end
                SbInjB:     begin w_v_en[t] = w_inj_b_en[t]; w_v_val[t] = w_inj_b_val[t]; end
                SbZ:        w_v_en[t] = 1'b0;
                default:    w_v_en[t] = 1'b0;
            endcase

            case (r_cfg[6*t+3 +: 3])
                SbStraight: begin w_h_en[t] = 1'b1;          w_h_val[t] = sc_H_i[t];      end
                SbTurn:     begin w_h_en[t] = 1'b1;          w_h_val[t] = sc_V_i[t];      end
                SbInjR:     begin w_h_en[t] = w_inj_r_en[t]; w_h_val[t] = w_inj_r_val[t]; end
                SbInjB:     begin w_h_en[t] = w_inj_b_en[t]; w_h_val[t] = w_inj_b_val[t]; end
                SbZ:        w_h_en[t] = 1'b0;
                default:    w_h_en[t] = 1'b0;
            endcase
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_track
        assign sc_V_o[g] = w_v_en[g] ? w_v_val[g] : 1'bz;
        assign sc_H_o[g] = w_h_en[g] ? w_h_val[g] : 1'bz;
    end

    // Reserved fields are stored but have no function.
    assign w_unused_cfg = ^{r_cfg[76:73], r_cfg[53:48], r_cfg[35:30]};

endmodule

// File: tb/tb_fpga_tile.sv
module tb_fpga_tile;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [76:0] bits;
    logic        cl_V_i, cl_H_i, lc_V_i, lc_H_i;
    logic [2:0]  sc_V_i, sc_H_i;
    wire         lc_V_o, lc_H_o, cl_V_o, cl_H_o;
    wire  [2:0]  sc_V_o, sc_H_o;

    int checks = 0;
    int errors = 0;

    fpga_tile dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (wr_en),
        .bits   (bits),
        .cl_V_i (cl_V_i),
        .cl_H_i (cl_H_i),
        .lc_V_i (lc_V_i),
        .lc_H_i (lc_H_i),
        .sc_V_i (sc_V_i),
        .sc_H_i (sc_H_i),
        .lc_V_o (lc_V_o),
        .lc_H_o (lc_H_o),
        .cl_V_o (cl_V_o),
        .cl_H_o (cl_H_o),
        .sc_V_o (sc_V_o),
        .sc_H_o (sc_H_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-track "is high impedance" flags
    wire [2:0] w_vz, w_hz;
    assign w_vz[0] = (sc_V_o[0] === 1'bz);
    assign w_vz[1] = (sc_V_o[1] === 1'bz);
    assign w_vz[2] = (sc_V_o[2] === 1'bz);
    assign w_hz[0] = (sc_H_o[0] === 1'bz);
    assign w_hz[1] = (sc_H_o[1] === 1'bz);
    assign w_hz[2] = (sc_H_o[2] === 1'bz);

    // ---------------- behavioural model ----------------
    logic [76:0] m_cfg;
    logic        m_ff;

    function automatic logic pick(input logic [2:0] sel, input logic [2:0] src);
        int n = 0;
        int idx = 0;
        for (int k = 0; k < 3; k++) if (sel[k]) begin n++; idx = k; end
        return (n == 1) ? src[idx] : 1'b0;
    endfunction

    function automatic logic model_lut(input logic [76:0] c);
        int addr;
        addr = int'(cl_V_i) * 8 + int'(pick(c[20:18], sc_H_i)) * 4
             + int'(pick(c[38:36], sc_V_i)) * 2 + int'(cl_H_i);
        return c[54 + addr];
    endfunction

    task automatic model_eval(input logic [76:0] c, input logic ff,
                              output logic lc, output logic clv, output logic clh,
                              output logic [2:0] ven, output logic [2:0] vval,
                              output logic [2:0] hen, output logic [2:0] hval);
        logic res, ro, dn;
        logic [1:0] rf, bf;
        logic [2:0] vc, hc;
        logic ren, rv, ben, bv;
        res = c[70] ? ff : model_lut(c);
        ro  = c[71] ? cl_H_i : res;
        dn  = c[72] ? cl_V_i : res;
        lc  = res;
        clh = pick(c[41:39], sc_V_i);
        clv = pick(c[23:21], sc_H_i);
        for (int t = 0; t < 3; t++) begin
            rf  = c[42+2*t +: 2];
            bf  = c[24+2*t +: 2];
            ren = (rf != 2'b00);
            rv  = rf[0] ? ro : lc_H_i;
            ben = (bf != 2'b00);
            bv  = bf[0] ? dn : lc_V_i;
            vc  = c[6*t +: 3];
            hc  = c[6*t+3 +: 3];
            ven[t] = 1'b0; vval[t] = 1'b0; hen[t] = 1'b0; hval[t] = 1'b0;
            if (vc == 3'd1) begin ven[t] = 1'b1; vval[t] = sc_V_i[t]; end
            if (vc == 3'd2) begin ven[t] = 1'b1; vval[t] = sc_H_i[t]; end
            if (vc == 3'd3) begin ven[t] = ren;  vval[t] = rv;        end
            if (vc == 3'd4) begin ven[t] = ben;  vval[t] = bv;        end
            if (hc == 3'd1) begin hen[t] = 1'b1; hval[t] = sc_H_i[t]; end
            if (hc == 3'd2) begin hen[t] = 1'b1; hval[t] = sc_V_i[t]; end
            if (hc == 3'd3) begin hen[t] = ren;  hval[t] = rv;        end
            if (hc == 3'd4) begin hen[t] = ben;  hval[t] = bv;        end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cfg <= '0;
            m_ff  <= 1'b0;
        end else begin
            m_ff <= model_lut(m_cfg);
            if (wr_en) m_cfg <= bits;
        end
    end

    // ---------------- check helpers ----------------
    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_z(input string name, input logic is_z);
        checks++;
        if (!is_z) begin
            errors++;
            $display("FAIL %s: got driven want z (t=%0t)", name, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        logic e_lc, e_clv, e_clh;
        logic [2:0] e_ven, e_vval, e_hen, e_hval;
        model_eval(m_cfg, m_ff, e_lc, e_clv, e_clh, e_ven, e_vval, e_hen, e_hval);
        chk("lc_V_o", lc_V_o, e_lc);
        chk("lc_H_o", lc_H_o, e_lc);
        chk("cl_V_o", cl_V_o, e_clv);
        chk("cl_H_o", cl_H_o, e_clh);
        for (int t = 0; t < 3; t++) begin
            if (e_ven[t]) chk($sformatf("sc_V_o[%0d]", t), sc_V_o[t], e_vval[t]);
            else          chk_z($sformatf("sc_V_o[%0d] z", t), w_vz[t]);
            if (e_hen[t]) chk($sformatf("sc_H_o[%0d]", t), sc_H_o[t], e_hval[t]);
            else          chk_z($sformatf("sc_H_o[%0d] z", t), w_hz[t]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic rand_inputs();
        logic [31:0] r;
        r = $urandom;
        cl_V_i = r[0];
        cl_H_i = r[1];
        lc_V_i = r[2];
        lc_H_i = r[3];
        sc_V_i = r[6:4];
        sc_H_i = r[9:7];
    endtask

    task automatic load(input logic [76:0] c);
        @(negedge clk); #1;
        bits  = c;
        wr_en = 1'b1;
        @(negedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " lc_V_o"}, lc_V_o, 1'b0);
        chk({tag, " lc_H_o"}, lc_H_o, 1'b0);
        chk({tag, " cl_V_o"}, cl_V_o, 1'b0);
        chk({tag, " cl_H_o"}, cl_H_o, 1'b0);
        chk_z({tag, " sc_V_o"}, &w_vz);
        chk_z({tag, " sc_H_o"}, &w_hz);
    endtask

    initial begin
        logic [76:0] c;
        logic [95:0] r96;
        logic [5:0]  v;
        logic        e;

        rst_n = 1'b0;
        wr_en = 1'b1;
        bits  = '1;
        rand_inputs();

        // Reset with wr_en pulsing: config must stay clear
        repeat (3) @(posedge clk);
        #2;
        chk_reset_outputs("reset");
        @(negedge clk); #1;
        wr_en = 1'b0;
        rst_n = 1'b1;
        rand_inputs();
        @(negedge clk); #1;
        chk_reset_outputs("post-reset");

        // LUT F888 with routed inputs, combinational
        c = '0;
        c[69:54] = 16'hF888;
        c[38:36] = 3'b001;
        c[20:18] = 3'b100;
        c[41:39] = 3'b010;
        c[23:21] = 3'b001;
        load(c);
        for (int i = 0; i < 64; i++) begin
            v = i[5:0];
            cl_V_i = v[0];
            sc_H_i = {v[1], 1'b0, v[5]};
            sc_V_i = {1'b0, v[4], v[2]};
            cl_H_i = v[3];
            #2;
            e = (v[0] & v[1]) | (v[2] & v[3]);
            chk("f888 lc_V_o", lc_V_o, e);
            chk("f888 lc_H_o", lc_H_o, e);
            chk("f888 cl_H_o", cl_H_o, v[4]);
            chk("f888 cl_V_o", cl_V_o, v[5]);
            @(negedge clk); #1;
        end

        // Switch block with CB_R injects
        c = '0;
        c[71]    = 1'b1;
        c[2:0]   = 3'b011;
        c[8:6]   = 3'b011;
        c[11:9]  = 3'b001;
        c[14:12] = 3'b001;
        c[43:42] = 2'b10;
        c[45:44] = 2'b01;
        load(c);
        for (int i = 0; i < 8; i++) begin
            rand_inputs();
            #2;
            chk("sb sc_V_o[0]", sc_V_o[0], lc_H_i);
            chk("sb sc_V_o[1]", sc_V_o[1], cl_H_i);
            chk("sb sc_V_o[2]", sc_V_o[2], sc_V_i[2]);
            chk("sb sc_H_o[1]", sc_H_o[1], sc_H_i[1]);
            chk_z("sb sc_H_o[0] z", w_hz[0]);
            chk_z("sb sc_H_o[2] z", w_hz[2]);
            @(negedge clk); #1;
        end

        // Turn code on H2
        c[17:15] = 3'b010;
        load(c);
        for (int i = 0; i < 4; i++) begin
            rand_inputs();
            #2;
            chk("turn sc_H_o[2]", sc_H_o[2], sc_V_i[2]);
            @(negedge clk); #1;
        end

        // Multi-hot selects give 0
        c = '0;
        c[69:54] = 16'hCCCC;
        c[38:36] = 3'b011;
        c[41:39] = 3'b011;
        load(c);
        sc_V_i = 3'b111;
        #2;
        chk("multihot lc_V_o", lc_V_o, 1'b0);
        chk("multihot cl_H_o", cl_H_o, 1'b0);

        // Registered output lags the LUT by one cycle
        c = '0;
        c[69:54] = 16'hAAAA;
        c[70]    = 1'b1;
        load(c);
        cl_H_i = 1'b0;
        @(negedge clk); #1;
        cl_H_i = 1'b1;
        #1;
        chk("ff before edge", lc_V_o, 1'b0);
        @(posedge clk); #1;
        chk("ff after edge", lc_V_o, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async reset");
        @(negedge clk); #1;
        rst_n = 1'b1;

        // Randomized traffic with occasional reloads and one reset pulse
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            rand_inputs();
            r96   = {$urandom, $urandom, $urandom};
            bits  = r96[76:0];
            wr_en = ($urandom_range(0, 5) == 0);
            if (i == 200) rst_n = 1'b0;
            if (i == 202) rst_n = 1'b1;
        end
        @(negedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
